parity_seq_ctrl: RTL and testbench

PARITY_SEQ_CTRL -- requirements
Module: parity_seq_ctrl

---
 rtl/parity_pkg.sv | 23 ++
 rtl/parity_serial_engine.sv | 28 ++
 rtl/parity_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_parity_seq_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared types, defaults and width helper for the parity sequencing controller.
package parity_pkg;

    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    typedef enum logic {
        EVEN,
        ODD
    } par_e;

    // Index width for n items; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/parity_serial_engine.sv
// Serial even/odd parity accumulator shared by all requesters.
module parity_serial_engine
    import parity_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic bit_valid,
    input  logic bit_in,
    output logic parity
);

    par_e state_q;

    // Toggle between EVEN and ODD on every valid 1 bit; clear wins over toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EVEN;
        end else if (clear) begin
            state_q <= EVEN;
        end else if (bit_valid && bit_in) begin
            state_q <= (state_q == EVEN) ? ODD : EVEN;
        end
    end

    assign parity = (state_q == ODD);

endmodule

// File: rtl/parity_seq_ctrl.sv
// Round-robin front end that feeds requester words bit-serially through one
// parity engine and reports parity / mismatch per word.
// Optional macro PARITY_ERR_CNT_EN adds a saturating 8-bit error counter (err_cnt).
module parity_seq_ctrl
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    input  logic [NUM_REQ-1:0]            req_exp,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          res_valid,
    output logic [id_width(NUM_REQ)-1:0]  res_id,
    output logic                          res_parity,
    output logic                          res_err,
    output logic                          busy
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [7:0]                    err_cnt
`endif
);

    localparam int unsigned ID_W  = id_width(NUM_REQ);
    localparam int unsigned CNT_W = id_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_e              state_q;
    logic [DATA_W-1:0]   word_q;
    logic                exp_q;
    logic [ID_W-1:0]     id_q;
    logic [ID_W-1:0]     last_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                res_valid_q;
    logic [ID_W-1:0]     res_id_q;
    logic                res_parity_q;
    logic                res_err_q;

    logic [NUM_REQ-1:0]  grant_d;
    logic [ID_W-1:0]     grant_idx_d;
    logic [ID_W-1:0]     cand_d;
    logic                found_d;
    logic                accept;
    logic                eng_parity;
    logic                final_parity;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        grant_d     = '0;
        grant_idx_d = '0;
        cand_d      = '0;
        found_d     = 1'b0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand_d = ID_W'((32'(last_q) + off) % NUM_REQ);
            if (!found_d && req_valid[cand_d]) begin
                found_d          = 1'b1;
                grant_d[cand_d]  = 1'b1;
                grant_idx_d      = cand_d;
            end
        end
    end

    // Ready is gated by rst so the async reset forces it low immediately.
    assign req_ready = (state_q == IDLE && !rst) ? grant_d : '0;
    assign accept    = (state_q == IDLE) && found_d && !rst;

    parity_serial_engine u_engine (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept),
        .bit_valid (state_q == SHIFT),
        .bit_in    (word_q[0]),
        .parity    (eng_parity)
    );

    // The engine has not yet absorbed the last bit when SHIFT exits, so fold it in here.
    assign final_parity = eng_parity ^ word_q[0];

    // Sequencer: capture on accept, shift LSB first, publish results on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            word_q       <= '0;
            exp_q        <= 1'b0;
            id_q         <= '0;
            last_q       <= ID_W'(NUM_REQ - 1);
            cnt_q        <= '0;
            res_valid_q  <= 1'b0;
            res_id_q     <= '0;
            res_parity_q <= 1'b0;
            res_err_q    <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= SHIFT;
                        word_q  <= req_data[32'(grant_idx_d) * DATA_W +: DATA_W];
                        exp_q   <= req_exp[grant_idx_d];
                        id_q    <= grant_idx_d;
                        last_q  <= grant_idx_d;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    word_q <= word_q >> 1;
                    if (cnt_q == LAST_BIT) begin
                        state_q      <= DONE;
                        res_valid_q  <= 1'b1;
                        res_id_q     <= id_q;
                        res_parity_q <= final_parity;
                        res_err_q    <= final_parity ^ exp_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign res_valid  = res_valid_q;
    assign res_id     = res_id_q;
    assign res_parity = res_parity_q;
    assign res_err    = res_err_q;
    assign busy       = (state_q != IDLE);

`ifdef PARITY_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Count reported parity errors, holding at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (res_valid_q && res_err_q && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_seq_ctrl.sv
// Directed self-checking bench for parity_seq_ctrl (DATA_W=8, NUM_REQ=2).
// Exercises the PARITY_ERR_CNT_EN counter when that macro is defined.
module tb_parity_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_exp;
    logic [1:0]  req_ready;
    logic        res_valid;
    logic [0:0]  res_id;
    logic        res_parity;
    logic        res_err;
    logic        busy;
`ifdef PARITY_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    parity_seq_ctrl #(.DATA_W(8), .NUM_REQ(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_exp    (req_exp),
        .req_ready  (req_ready),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .res_parity (res_parity),
        .res_err    (res_err),
        .busy       (busy)
`ifdef PARITY_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        tests_run++;
        if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL reset_ready: got %0h want 0", req_ready); end
        tests_run++;
        if ({busy, res_valid, res_id, res_parity, res_err} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got busy=%0b vld=%0b id=%0h par=%0b err=%0b want all 0",
                     busy, res_valid, res_id, res_parity, res_err);
        end
`ifdef PARITY_ERR_CNT_EN
        tests_run++;
        if (err_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
`endif
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_word();
        logic early;
        early = 1'b0;
        @(negedge clk);
        req_valid = 2'b01; req_data = 16'h00A5; req_exp = 2'b00;
        #1;
        tests_run++;
        if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL single_ready: got %0h want 1", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        tests_run++;
        if (req_ready !== 2'b00 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL single_busy: got ready=%0h busy=%0b want ready=0 busy=1", req_ready, busy);
        end
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk); #1;
            if (k < 9 && res_valid) early = 1'b1;
        end
        tests_run++;
        if (early !== 1'b0 || res_valid !== 1'b1) begin
            tests_failed++; $display("FAIL single_latency: got early=%0b vld=%0b want early=0 vld=1", early, res_valid);
        end
        tests_run++;
        if ({res_id, res_parity, res_err} !== 3'b000) begin
            tests_failed++; $display("FAIL single_result: got id=%0h par=%0b err=%0b want 0 0 0", res_id, res_parity, res_err);
        end
        @(negedge clk); #1;
        tests_run++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL single_one_cycle: got vld=%0b busy=%0b want 0 0", res_valid, busy);
        end
    endtask

    task automatic test_error_detect();
        @(negedge clk);
        req_valid = 2'b10; req_data = 16'h0700; req_exp = 2'b00;
        #1;
        tests_run++;
        if (req_ready !== 2'b10) begin tests_failed++; $display("FAIL err_ready: got %0h want 2", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        for (int k = 2; k <= 9; k++) begin @(negedge clk); #1; end
        tests_run++;
        if ({res_valid, res_id, res_parity, res_err} !== 4'b1111) begin
            tests_failed++;
            $display("FAIL err_result: got vld=%0b id=%0h par=%0b err=%0b want 1 1 1 1", res_valid, res_id, res_parity, res_err);
        end
        @(negedge clk); #1;
        tests_run++;
        if ({res_valid, res_id, res_parity, res_err} !== 4'b0111) begin
            tests_failed++;
            $display("FAIL err_hold: got vld=%0b id=%0h par=%0b err=%0b want 0 1 1 1", res_valid, res_id, res_parity, res_err);
        end
`ifdef PARITY_ERR_CNT_EN
        tests_run++;
        if (err_cnt !== 8'd1) begin tests_failed++; $display("FAIL err_cnt_one: got %0d want 1", err_cnt); end
`endif
    endtask

    task automatic test_contention();
        logic [1:0] gseq[$];
        logic       rid[$];
        logic       rpar[$];
        logic       rerr[$];
        int         rcyc[$];
        logic [1:0] exp_g;
        @(negedge clk);
        req_valid = 2'b11; req_data = 16'h01FF; req_exp = 2'b00;
        #1;
        for (int c = 0; c < 45; c++) begin
            if (req_ready !== 2'b00) gseq.push_back(req_ready);
            if (res_valid) begin
                rid.push_back(res_id[0]); rpar.push_back(res_parity);
                rerr.push_back(res_err); rcyc.push_back(c);
            end
            @(negedge clk); #1;
        end
        req_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            tests_run++;
            if (k >= gseq.size() || gseq[k] !== exp_g) begin
                tests_failed++; $display("FAIL contention_grant%0d: got %0h want %0h", k, (k < gseq.size()) ? gseq[k] : 2'b00, exp_g);
            end
            tests_run++;
            if (k >= rid.size() || rid[k] !== 1'(k % 2) || rpar[k] !== 1'(k % 2) || rerr[k] !== 1'(k % 2)) begin
                tests_failed++; $display("FAIL contention_result%0d: got %0d results, want id=par=err=%0d", k, rid.size(), k % 2);
            end
        end
        for (int k = 1; k < 4; k++) begin
            tests_run++;
            if (k >= rcyc.size() || rcyc[k] - rcyc[k-1] != 10) begin
                tests_failed++; $display("FAIL contention_spacing%0d: got %0d results, want 10-cycle spacing", k, rcyc.size());
            end
        end
        for (int k = 0; k < 20 && busy; k++) begin @(negedge clk); #1; end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL contention_drain: got busy=%0b want 0", busy); end
    endtask

    task automatic test_reset_mid_shift();
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        req_valid = 2'b01; req_data = 16'h00FF; req_exp = 2'b00;
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if ({busy, res_valid, req_ready} !== 4'b0) begin
            tests_failed++; $display("FAIL rst_mid_async: got busy=%0b vld=%0b ready=%0h want 0", busy, res_valid, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin @(negedge clk); #1; if (res_valid || busy) seen = 1'b1; end
        tests_run++;
        if (seen !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_no_result: got activity=%0b want 0", seen); end
        req_valid = 2'b11; req_data = 16'h0101;
        #1;
        tests_run++;
        if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL rst_mid_pointer: got %0h want 1", req_ready); end
        req_valid = 2'b00;
        #1;
        tests_run++;
        if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL withdraw_ready: got %0h want 0", req_ready); end
        @(negedge clk); #1;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL withdraw_no_accept: got busy=%0b want 0", busy); end
    endtask

    task automatic test_stall();
        logic bad, got, r_id, r_par, r_err;
        bad = 1'b0; got = 1'b0; r_id = 1'b0; r_par = 1'b0; r_err = 1'b0;
        @(negedge clk);
        req_valid = 2'b01; req_data = 16'h003C; req_exp = 2'b01;
        #1;
        tests_run++;
        if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL stall_first_ready: got %0h want 1", req_ready); end
        @(negedge clk);
        // Requester 0 moves on; requester 1 waits; the captured word must not change.
        req_valid = 2'b10; req_data = 16'h8001; req_exp = 2'b11;
        #1;
        for (int k = 0; k < 20; k++) begin
            if (!busy) break;
            if (req_ready !== 2'b00) bad = 1'b1;
            if (res_valid) begin got = 1'b1; r_id = res_id[0]; r_par = res_parity; r_err = res_err; end
            @(negedge clk); #1;
        end
        tests_run++;
        if (busy !== 1'b0 || bad !== 1'b0) begin
            tests_failed++; $display("FAIL stall_ready_low: got busy=%0b ready_seen=%0b want 0 0", busy, bad);
        end
        tests_run++;
        if ({got, r_id, r_par, r_err} !== 4'b1001) begin
            tests_failed++; $display("FAIL stall_first_result: got seen=%0b id=%0b par=%0b err=%0b want 1 0 0 1", got, r_id, r_par, r_err);
        end
        tests_run++;
        if (req_ready !== 2'b10) begin tests_failed++; $display("FAIL stall_second_ready: got %0h want 2", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk); #1;
            if (res_valid) begin got = 1'b1; r_id = res_id[0]; r_par = res_parity; r_err = res_err; end
        end
        tests_run++;
        if ({got, r_id, r_par, r_err} !== 4'b1110) begin
            tests_failed++; $display("FAIL stall_second_result: got seen=%0b id=%0b par=%0b err=%0b want 1 1 1 0", got, r_id, r_par, r_err);
        end
        @(negedge clk); #1;
    endtask

`ifdef PARITY_ERR_CNT_EN
    task automatic test_saturation();
        int   pulses;
        logic bad;
        pulses = 0; bad = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (err_cnt !== 8'd0) begin tests_failed++; $display("FAIL sat_cleared: got %0d want 0", err_cnt); end
        req_valid = 2'b01; req_data = 16'h0001; req_exp = 2'b00;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk); #1;
            if (res_valid) begin
                if (err_cnt !== 8'((pulses < 255) ? pulses : 255)) bad = 1'b1;
                pulses++;
                if (pulses == 260) req_valid = 2'b00;
            end
            if (pulses >= 260 && !busy) break;
        end
        @(negedge clk); #1;
        tests_run++;
        if (pulses != 260 || bad !== 1'b0) begin
            tests_failed++; $display("FAIL sat_progress: got pulses=%0d step_err=%0b want 260 0", pulses, bad);
        end
        tests_run++;
        if (err_cnt !== 8'd255) begin tests_failed++; $display("FAIL sat_final: got %0d want 255", err_cnt); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 2'b00; req_data = 16'h0000; req_exp = 2'b00;
        test_reset();
        test_single_word();
        test_error_detect();
        test_contention();
        test_reset_mid_shift();
        test_stall();
`ifdef PARITY_ERR_CNT_EN
        test_saturation();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
